lpc_host_io: RTL
================

LPC_HOST_IO -- requirements
Module: lpc_host_io

Interface
REQ-001 SHALL have parameter SYNC_TIMEOUT, default 8, max consecutive short-wait/no-response SYNC cycles before abort (range 2..255).
REQ-002 SHALL have parameter ABORT_CYCLES, default 4, LFrameN-low clocks in abort (minimum 4).
REQ-003 SHALL have port LpcClock  in  1  33 MHz LPC clock; all logic on rising edge.
REQ-004 SHALL have port PciReset  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ReqValid  in  1  request present.
REQ-006 SHALL have port ReqReady  out  1  request accepted when ReqValid&ReqReady.
REQ-007 SHALL have port ReqWrite  in  1  1 = I/O write, 0 = I/O read.
REQ-008 SHALL have port ReqAddr  in  16  I/O address.
REQ-009 SHALL have port ReqWData  in  8  write data.
REQ-010 SHALL have port RspValid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port RspRData  out  8  read data, valid with RspValid on reads.
REQ-012 SHALL have port RspStatus  out  2  00 ok, 01 SYNC error, 10 timeout.
REQ-013 SHALL have port LFrameN  out  1  LPC frame, active-low.
REQ-014 SHALL have port LadOut  out  4  LAD drive value.
REQ-015 SHALL have port LadOe  out  1  LAD output enable; pad tristates when 0.
REQ-016 SHALL have port LadIn  in  4  sampled LAD.

Function
REQ-017 All outputs registered; ReqReady=1 only in IDLE; request fields latched on acceptance; ReqValid ignored outside IDLE.
REQ-018 State sequence, one clock each unless noted: IDLE, START, CYCTYPE, ADDR x4, [write: WDATA x2], HTAR0, HTAR1, SYNC (1..n), [read: RDATA x2], PTAR0, PTAR1, IDLE.
REQ-019 START: LFrameN=0, LadOe=1, LadOut=0000; LFrameN=1 in every other non-abort state.
REQ-020 CYCTYPE: LadOut=0010 write, 0000 read.
REQ-021 ADDR: nibbles ReqAddr[15:12],[11:8],[7:4],[3:0] in that order.
REQ-022 WDATA: ReqWData[3:0] then [7:4] (low nibble first).
REQ-023 HTAR0: LadOe=1, LadOut=1111; HTAR1 onward through PTAR1: LadOe=0.
REQ-024 SYNC sampling of LadIn: 0000 ready -> RDATA (read) or PTAR0 (write); 0101 short wait and 1111 no-response -> stay, increment timeout count; 0110 long wait -> stay, count held; 1010 -> latch status 01, continue as ready (data phase still taken on reads); any other value -> status 01, go to PTAR0 without data phase.
REQ-025 Timeout count clears on entry to SYNC; on reaching SYNC_TIMEOUT -> ABORT, status 10.
REQ-026 RDATA: first cycle captures LadIn into RspRData[3:0], second into [7:4].
REQ-027 ABORT: LFrameN=0, LadOe=1, LadOut=1111 for ABORT_CYCLES clocks, then one clock LFrameN=1, LadOe=0, then IDLE.
REQ-028 RspValid pulses for one clock on the IDLE re-entry edge, with RspStatus; RspRData=00 on write/timeout; status held until next RspValid.
REQ-029 Latency: acceptance at edge T -> START at T+1; with immediate ready SYNC, read and write both complete with RspValid at T+14.
REQ-030 Back-to-back: ReqReady asserted in the RspValid cycle; new START no earlier than one clock after.
REQ-031 Long wait unbounded; only PciReset or ready/error ends it.

Reset
REQ-032 PciReset low asynchronously forces IDLE, LFrameN=1, LadOe=0, LadOut=1111, ReqReady=0 during reset then 1, RspValid=0, RspStatus=00, RspRData=00, counters 0.
REQ-033 Reset mid-cycle abandons the transfer with no RspValid; bus released the same clock.

Structure
REQ-034 Shared package lpc_pkg SHALL hold state enum, CYCTYPE codes, SYNC codes (0000, 0101, 0110, 1010), START 0000, TAR 1111, status codes.
REQ-035 One sub-module lpc_sync_timer: SYNC_TIMEOUT counter with clear/inc/hold inputs and expired output.

Verification
REQ-036 Write 0x0080<=0xA5, SYNC 0000 first cycle -> LAD 0000,0010,0,0,8,0,5,A,F; RspValid at T+14, status 00.
REQ-037 Read 0x002E, peripheral SYNC 0101 x3 then 0000, data 3C -> RspRData=3C, status 00, RspValid at T+17.
REQ-038 Read with LadIn held 1111 -> after 8 SYNC cycles LFrameN low 4 clocks, LAD=1111, RspStatus=10, RspRData=00.
REQ-039 Write with SYNC 0110 for 50 cycles then 0000 -> no abort, status 00.
REQ-040 Read with SYNC 1010, data 77 -> RspRData=77, status 01.
REQ-041 PciReset asserted during ADDR[2] -> LFrameN=1, LadOe=0 immediately, no RspValid; next request completes normally.

Source files
------------

// File: rtl/lpc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lpc_pkg : state encoding and LAD code points shared by the LPC host  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lpc_pkg;

    typedef enum logic [4:0] {
        ST_IDLE     = 5'd0,
        ST_START    = 5'd1,
        ST_CYCTYPE  = 5'd2,
        ST_ADDR0    = 5'd3,
        ST_ADDR1    = 5'd4,
        ST_ADDR2    = 5'd5,
        ST_ADDR3    = 5'd6,
        ST_WDATA0   = 5'd7,
        ST_WDATA1   = 5'd8,
        ST_HTAR0    = 5'd9,
        ST_HTAR1    = 5'd10,
        ST_SYNC     = 5'd11,
        ST_RDATA0   = 5'd12,
        ST_RDATA1   = 5'd13,
        ST_PTAR0    = 5'd14,
        ST_PTAR1    = 5'd15,
        ST_ABORT    = 5'd16,
        ST_ABORTREL = 5'd17
    } lpcState_t;

    localparam logic [3:0] c_LAD_START      = 4'b0000;
    localparam logic [3:0] c_LAD_TAR        = 4'b1111;

    localparam logic [3:0] c_CYC_IO_READ    = 4'b0000;
    localparam logic [3:0] c_CYC_IO_WRITE   = 4'b0010;

    localparam logic [3:0] c_SYNC_READY     = 4'b0000;
    localparam logic [3:0] c_SYNC_SHORT     = 4'b0101;
    localparam logic [3:0] c_SYNC_LONG      = 4'b0110;
    localparam logic [3:0] c_SYNC_ERROR     = 4'b1010;
    localparam logic [3:0] c_SYNC_NORESP    = 4'b1111;

    localparam logic [1:0] c_STATUS_OK      = 2'b00;
    localparam logic [1:0] c_STATUS_SYNCERR = 2'b01;
    localparam logic [1:0] c_STATUS_TIMEOUT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/lpc_sync_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lpc_sync_timer : counts short-wait / no-response SYNC cycles         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lpc_sync_timer #(
    parameter int SYNC_TIMEOUT = 8
) (
    input  logic LpcClock,
    input  logic PciReset,
    input  logic clear,
    input  logic inc,
    input  logic hold,
    output logic expired
);

    logic [7:0] r_count;

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            r_count <= 8'd0;
        end else if (clear) begin
            r_count <= 8'd0;
        end else if (hold) begin
            r_count <= r_count;
        end else if (inc) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Asserted when the next increment reaches the limit, so the host aborts
    // on exactly the SYNC_TIMEOUT-th counted cycle.
    assign expired = (r_count == 8'(SYNC_TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/lpc_host_io.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lpc_host_io : LPC host master for single-byte I/O read/write cycles  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lpc_host_io
    import lpc_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 8,
    parameter int ABORT_CYCLES = 4
) (
    input  logic        LpcClock,
    input  logic        PciReset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [15:0] ReqAddr,
    input  logic [7:0]  ReqWData,
    output logic        RspValid,
    output logic [7:0]  RspRData,
    output logic [1:0]  RspStatus,
    output logic        LFrameN,
    output logic [3:0]  LadOut,
    output logic        LadOe,
    input  logic [3:0]  LadIn
);

    lpcState_t   r_state;
    lpcState_t   w_nextState;
    logic        r_pending;
    logic        r_write;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic [1:0]  r_status;
    logic [15:0] r_abortCnt;

    logic        w_accept;
    logic        w_timerClear;
    logic        w_timerInc;
    logic        w_timerHold;
    logic        w_timerExpired;
    logic        w_statusSet;
    logic [1:0]  w_statusVal;
    logic        w_complete;
    logic        w_frameN;
    logic        w_oe;
    logic [3:0]  w_lad;

    assign w_accept     = ReqValid && ReqReady;
    assign w_timerClear = (r_state == ST_HTAR1);

    lpc_sync_timer #(
        .SYNC_TIMEOUT (SYNC_TIMEOUT)
    ) u_syncTimer (
        .LpcClock (LpcClock),
        .PciReset (PciReset),
        .clear    (w_timerClear),
        .inc      (w_timerInc),
        .hold     (w_timerHold),
        .expired  (w_timerExpired)
    );

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_timerInc  = 1'b0;
        w_timerHold = 1'b0;
        w_statusSet = 1'b0;
        w_statusVal = c_STATUS_OK;
        w_complete  = 1'b0;
        unique case (r_state)
            ST_IDLE:     if (r_pending) w_nextState = ST_START;
            ST_START:    w_nextState = ST_CYCTYPE;
            ST_CYCTYPE:  w_nextState = ST_ADDR0;
            ST_ADDR0:    w_nextState = ST_ADDR1;
            ST_ADDR1:    w_nextState = ST_ADDR2;
            ST_ADDR2:    w_nextState = ST_ADDR3;
            ST_ADDR3:    w_nextState = r_write ? ST_WDATA0 : ST_HTAR0;
            ST_WDATA0:   w_nextState = ST_WDATA1;
            ST_WDATA1:   w_nextState = ST_HTAR0;
            ST_HTAR0:    w_nextState = ST_HTAR1;
            ST_HTAR1:    w_nextState = ST_SYNC;
            ST_SYNC: begin
                case (LadIn)
                    c_SYNC_READY: begin
                        w_nextState = r_write ? ST_PTAR0 : ST_RDATA0;
                    end
                    // Error SYNC still completes the data phase on reads.
                    c_SYNC_ERROR: begin
                        w_statusSet = 1'b1;
                        w_statusVal = c_STATUS_SYNCERR;
                        w_nextState = r_write ? ST_PTAR0 : ST_RDATA0;
                    end
                    c_SYNC_SHORT, c_SYNC_NORESP: begin
                        w_timerInc = 1'b1;
                        if (w_timerExpired) begin
                            w_statusSet = 1'b1;
                            w_statusVal = c_STATUS_TIMEOUT;
                            w_nextState = ST_ABORT;
                        end
                    end
                    c_SYNC_LONG: begin
                        w_timerHold = 1'b1;
                    end
                    default: begin
                        w_statusSet = 1'b1;
                        w_statusVal = c_STATUS_SYNCERR;
                        w_nextState = ST_PTAR0;
                    end
                endcase
            end
            ST_RDATA0:   w_nextState = ST_RDATA1;
            ST_RDATA1:   w_nextState = ST_PTAR0;
            ST_PTAR0:    w_nextState = ST_PTAR1;
            ST_PTAR1: begin
                w_nextState = ST_IDLE;
                w_complete  = 1'b1;
            end
            ST_ABORT: begin
                if (r_abortCnt == 16'(ABORT_CYCLES - 1)) w_nextState = ST_ABORTREL;
            end
            ST_ABORTREL: begin
                w_nextState = ST_IDLE;
                w_complete  = 1'b1;
            end
            default:     w_nextState = ST_IDLE;
        endcase
    end

    // Bus pins are registered from the next state so they line up with r_state.
    always_comb begin
        w_frameN = 1'b1;
        w_oe     = 1'b0;
        w_lad    = c_LAD_TAR;
        unique case (w_nextState)
            ST_START: begin
                w_frameN = 1'b0;
                w_oe     = 1'b1;
                w_lad    = c_LAD_START;
            end
            ST_CYCTYPE: begin
                w_oe  = 1'b1;
                w_lad = r_write ? c_CYC_IO_WRITE : c_CYC_IO_READ;
            end
            ST_ADDR0:  begin w_oe = 1'b1; w_lad = r_addr[15:12]; end
            ST_ADDR1:  begin w_oe = 1'b1; w_lad = r_addr[11:8];  end
            ST_ADDR2:  begin w_oe = 1'b1; w_lad = r_addr[7:4];   end
            ST_ADDR3:  begin w_oe = 1'b1; w_lad = r_addr[3:0];   end
            ST_WDATA0: begin w_oe = 1'b1; w_lad = r_wdata[3:0];  end
            ST_WDATA1: begin w_oe = 1'b1; w_lad = r_wdata[7:4];  end
            ST_HTAR0:  begin w_oe = 1'b1; w_lad = c_LAD_TAR;     end
            ST_ABORT: begin
                w_frameN = 1'b0;
                w_oe     = 1'b1;
                w_lad    = c_LAD_TAR;
            end
            default: begin
                w_frameN = 1'b1;
                w_oe     = 1'b0;
                w_lad    = c_LAD_TAR;
            end
        endcase
    end

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            r_pending  <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= 16'h0000;
            r_wdata    <= 8'h00;
            r_rdata    <= 8'h00;
            r_status   <= c_STATUS_OK;
            r_abortCnt <= 16'd0;
            ReqReady   <= 1'b0;
            RspValid   <= 1'b0;
            RspStatus  <= c_STATUS_OK;
            RspRData   <= 8'h00;
            LFrameN    <= 1'b1;
            LadOe      <= 1'b0;
            LadOut     <= c_LAD_TAR;
        end else begin
            r_pending <= w_accept;
            if (w_accept) begin
                r_write  <= ReqWrite;
                r_addr   <= ReqAddr;
                r_wdata  <= ReqWData;
                r_rdata  <= 8'h00;
                r_status <= c_STATUS_OK;
            end
            if (r_state == ST_RDATA0) r_rdata[3:0] <= LadIn;
            if (r_state == ST_RDATA1) r_rdata[7:4] <= LadIn;
            if (w_statusSet) r_status <= w_statusVal;
            r_abortCnt <= (r_state == ST_ABORT) ? r_abortCnt + 16'd1 : 16'd0;

            ReqReady <= (w_nextState == ST_IDLE) && !w_accept;
            LFrameN  <= w_frameN;
            LadOe    <= w_oe;
            LadOut   <= w_lad;
            RspValid <= w_complete;
            if (w_complete) begin
                RspStatus <= r_status;
                RspRData  <= r_rdata;
            end
        end
    end

endmodule
`default_nettype wire
